muldiv_ctrl: RTL

Sequencing controller for the multiply/divide resource in the EX stage. It decodes MULT/MULTU/DIV/DIVU from `ex_alucontrol`, latches operands, runs the fixed-latency multiplier and the iterative divider, and raises `muldiv_stall` to the hazard unit while an operation is in flight. It holds the 64-bit result until EX is free to advance, then issues a single HI/LO write. Exception flush cancels the operation.

---
 rtl/muldiv_ctrl_pkg.sv | 22 ++
 rtl/muldiv_ctrl_mul_pipe.sv | 58 +++++
 rtl/muldiv_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and ALU control codes for the EX-stage multiply/divide controller.
// Holds the state encodings and the operand sign-extension helper.
package muldiv_ctrl_pkg;

   localparam logic [4:0] MULT_CONTROL  = 5'b11000;
   localparam logic [4:0] MULTU_CONTROL = 5'b11001;
   localparam logic [4:0] DIV_CONTROL   = 5'b11010;
   localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

   // Widen a 32-bit operand to 33 bits; unsigned ops get a zero MSB.
   function automatic logic [32:0] ext33(input logic [31:0] v, input logic sgn);
      return {sgn & v[31], v};
   endfunction

endpackage

// File: rtl/muldiv_ctrl_mul_pipe.sv
// mul_pipe: MUL_LAT-stage registered 33x33 signed multiplier, 64-bit truncated product.
// Pure datapath: operands are registered on every edge, no enables or handshakes.
module mul_pipe #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [32:0] i_a,
   input  logic [32:0] i_b,
   output logic [63:0] o_prod
);

   logic [32:0]        r_a;
   logic [32:0]        r_b;
   logic signed [63:0] w_a64;
   logic signed [63:0] w_b64;
   logic [63:0]        w_prod;

   // First stage: capture operands.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_a <= 33'd0;
         r_b <= 33'd0;
      end else begin
         r_a <= i_a;
         r_b <= i_b;
      end
   end

   assign w_a64  = {{31{r_a[32]}}, r_a};
   assign w_b64  = {{31{r_b[32]}}, r_b};
   assign w_prod = w_a64 * w_b64;

   generate
      if (MUL_LAT <= 1) begin : g_lat1
         assign o_prod = w_prod;
      end else begin : g_latn
         logic [63:0] r_stage [0:MUL_LAT-2];

         // Remaining stages delay the product so it is valid MUL_LAT edges after capture.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int k = 0; k < MUL_LAT - 1; k++) begin
                  r_stage[k] <= 64'd0;
               end
            end else begin
               r_stage[0] <= w_prod;
               for (int k = 1; k < MUL_LAT - 1; k++) begin
                  r_stage[k] <= r_stage[k-1];
               end
            end
         end

         assign o_prod = r_stage[MUL_LAT-2];
      end
   endgenerate

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/MULTU/DIV/DIVU, stalls EX while busy, issues one HI/LO write.
// Optional feature macro DIV_ZERO_FAST_EN: divide by zero skips the divider and writes 0.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [4:0]  ex_alucontrol,
   input  logic [31:0] ex_srca,
   input  logic [31:0] ex_srcb,
   input  logic        flush,
   input  logic        ex_stall_ext,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_opa,
   output logic [31:0] div_opb,
   output logic        div_annul,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        muldiv_stall,
   output logic        hilo_we,
   output logic [63:0] hilo_wdata
);

   localparam logic [2:0] MCNT_INIT = 3'(MUL_LAT - 1);

   md_state_t   r_state;
   logic [2:0]  r_mcnt;
   logic [63:0] r_res;
   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic        r_signed;

   logic        w_is_mul;
   logic        w_is_div;
   logic        w_signed_op;
   logic        w_div_zero;
   logic [32:0] w_mul_a;
   logic [32:0] w_mul_b;
   logic [63:0] w_mul_prod;
   logic        w_stall;
   logic        w_start;
   logic        w_annul;
   logic        w_we;

   assign w_is_mul    = (ex_alucontrol == MULT_CONTROL) || (ex_alucontrol == MULTU_CONTROL);
   assign w_is_div    = (ex_alucontrol == DIV_CONTROL)  || (ex_alucontrol == DIVU_CONTROL);
   assign w_signed_op = (ex_alucontrol == MULT_CONTROL) || (ex_alucontrol == DIV_CONTROL);

`ifdef DIV_ZERO_FAST_EN
   assign w_div_zero = (ex_srcb == 32'd0);
`else
   assign w_div_zero = 1'b0;
`endif

   // The multiplier samples the EX operands directly so its first stage lands on the decode edge.
   assign w_mul_a = ext33(ex_srca, w_signed_op);
   assign w_mul_b = ext33(ex_srcb, w_signed_op);

   mul_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_mul_pipe (
      .clk    (clk),
      .resetn (resetn),
      .i_a    (w_mul_a),
      .i_b    (w_mul_b),
      .o_prod (w_mul_prod)
   );

   // Control FSM with operand and result registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= MD_IDLE;
         r_mcnt   <= 3'd0;
         r_res    <= 64'd0;
         r_opa    <= 32'd0;
         r_opb    <= 32'd0;
         r_signed <= 1'b0;
      end else if (flush) begin
         r_state <= MD_IDLE;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (w_is_mul) begin
                  r_opa    <= ex_srca;
                  r_opb    <= ex_srcb;
                  r_signed <= w_signed_op;
                  r_mcnt   <= MCNT_INIT;
                  r_state  <= MD_MUL;
               end else if (w_is_div) begin
                  r_opa    <= ex_srca;
                  r_opb    <= ex_srcb;
                  r_signed <= w_signed_op;
                  if (w_div_zero) begin
                     r_res   <= 64'd0;
                     r_state <= MD_DONE;
                  end else begin
                     r_state <= MD_DIV;
                  end
               end else begin
                  r_state <= MD_IDLE;
               end
            end
            MD_MUL: begin
               if (r_mcnt == 3'd0) begin
                  r_res   <= w_mul_prod;
                  r_state <= MD_DONE;
               end else begin
                  r_mcnt <= r_mcnt - 3'd1;
               end
            end
            MD_DIV: begin
               if (div_ready) begin
                  r_res   <= div_result;
                  r_state <= MD_DONE;
               end else begin
                  r_state <= MD_DIV;
               end
            end
            MD_DONE: begin
               if (!ex_stall_ext) begin
                  r_state <= MD_IDLE;
               end else begin
                  r_state <= MD_DONE;
               end
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   // Stall, divider handshake and write strobe are decoded from the current state.
   always_comb begin
      w_stall = 1'b0;
      w_start = 1'b0;
      w_annul = 1'b0;
      w_we    = 1'b0;
      case (r_state)
         MD_IDLE: w_stall = (w_is_mul | w_is_div) & ~flush;
         MD_MUL:  w_stall = 1'b1;
         MD_DIV: begin
            w_stall = 1'b1;
            w_start = ~div_ready & ~flush;
            w_annul = flush;
         end
         MD_DONE: w_we = ~ex_stall_ext & ~flush;
         default: w_stall = 1'b0;
      endcase
   end

   // Stall is decoded from live inputs in IDLE, so it is gated to stay low during reset.
   assign muldiv_stall = resetn & w_stall;
   assign div_start    = w_start;
   assign div_annul    = w_annul;
   assign hilo_we      = w_we;
   assign hilo_wdata   = r_res;
   assign div_opa      = r_opa;
   assign div_opb      = r_opb;
   assign div_signed   = r_signed;

endmodule
